// File: rtl/ps4_pkg.sv
// Shared helpers for the priority selector tree.
package ps4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Width of a binary index that can address every request line.
  function automatic int idxWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ps4_ps2.sv
// Two-input priority cell: the upper request beats the lower one.
module ps2 (
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       req_any
);

  // Upper input wins whenever it requests. Lower input is masked by the upper request.
  always_comb begin
    gnt[1]  = en & req[1];
    gnt[0]  = en & req[0] & ~req[1];
    req_any = |req;
  end

endmodule

// File: rtl/ps4.sv
// Fixed-priority selector: highest-indexed request wins, with a one-hot grant.
// The grant is built as a tree of ps2 cells. Request-any signals flow up the
// tree, and the enable flows down from the root, so WIDTH scales by adding levels.
module ps4 import ps4_pkg::*; #(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int IDX_W = idxWidth(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             en,
  output logic [WIDTH-1:0] gnt,
  output logic             gnt_any,
  output logic             req_any,
  output logic [IDX_W-1:0] gnt_idx,
  output logic [WIDTH-1:0] gnt_q,
  output logic             gnt_any_q
);

  logic [WIDTH-1:0] w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] r_gnt;
  logic             r_gnt_any;

  // Level 0 sits at the leaves and sees the raw requests. Level IDX_W-1 is the
  // root and receives the global enable. Each cell's grant outputs become the
  // enables of the two cells below it. A subtree is therefore enabled only when
  // its parent is enabled and its upper sibling has no request.
  for (genvar l = 0; l < IDX_W; l++) begin : gen_lvl
    localparam int CELLS = WIDTH >> (l + 1);

    logic [2*CELLS-1:0] w_req;
    logic [2*CELLS-1:0] w_cellGnt;
    logic [CELLS-1:0]   w_en;
    logic [CELLS-1:0]   w_any;

    if (l == 0) begin : gen_leafReq
      assign w_req = req;
    end else begin : gen_innerReq
      assign w_req = gen_lvl[l-1].w_any;
    end

    if (l == IDX_W - 1) begin : gen_rootEn
      assign w_en = en;
    end else begin : gen_innerEn
      assign w_en = gen_lvl[l+1].w_cellGnt;
    end

    for (genvar c = 0; c < CELLS; c++) begin : gen_cell
      ps2 u_cell (
        .req     (w_req[2*c+1:2*c]),
        .en      (w_en[c]),
        .gnt     (w_cellGnt[2*c+1:2*c]),
        .req_any (w_any[c])
      );
    end
  end

  assign w_gnt   = gen_lvl[0].w_cellGnt;
  assign req_any = gen_lvl[IDX_W-1].w_any[0];

  // The grant is at most one-hot, so OR-ing together the index of every set bit
  // gives the encoded position. With no grant, the result is 0.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_gnt[i]) begin
        w_idx = w_idx | IDX_W'(i);
      end
    end
  end

  // Registered copy for pipelined consumers. It is cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gnt     <= '0;
      r_gnt_any <= 1'b0;
    end else begin
      r_gnt     <= w_gnt;
      r_gnt_any <= |w_gnt;
    end
  end

  assign gnt       = w_gnt;
  assign gnt_any   = |w_gnt;
  assign gnt_idx   = w_idx;
  assign gnt_q     = r_gnt;
  assign gnt_any_q = r_gnt_any;

endmodule

// File: tb/tb_ps4.sv
// Self-checking bench for ps4 at WIDTH=4 and WIDTH=8.
module tb_ps4;

  logic clock = 1'b0;
  logic reset;

  logic [3:0] req4;
  logic       en4;
  logic [3:0] gnt4;
  logic       gntAny4;
  logic       reqAny4;
  logic [1:0] idx4;
  logic [3:0] gntQ4;
  logic       gntAnyQ4;

  logic [7:0] req8;
  logic       en8;
  logic [7:0] gnt8;
  logic       gntAny8;
  logic       reqAny8;
  logic [2:0] idx8;
  logic [7:0] gntQ8;
  logic       gntAnyQ8;

  logic [7:0] expQ4;
  logic [7:0] expQ8;

  int passCount  = 0;
  int checkCount = 0;

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  ps4 #(.WIDTH(4)) u_dut4 (
    .clock     (clock),
    .reset     (reset),
    .req       (req4),
    .en        (en4),
    .gnt       (gnt4),
    .gnt_any   (gntAny4),
    .req_any   (reqAny4),
    .gnt_idx   (idx4),
    .gnt_q     (gntQ4),
    .gnt_any_q (gntAnyQ4)
  );

  ps4 #(.WIDTH(8)) u_dut8 (
    .clock     (clock),
    .reset     (reset),
    .req       (req8),
    .en        (en8),
    .gnt       (gnt8),
    .gnt_any   (gntAny8),
    .req_any   (reqAny8),
    .gnt_idx   (idx8),
    .gnt_q     (gntQ8),
    .gnt_any_q (gntAnyQ8)
  );

  // Reference grant: scan from the top bit down and keep the first request found.
  function automatic logic [7:0] refGnt(input logic [7:0] r, input logic e, input int w);
    logic [7:0] g;
    logic found;
    g = '0;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (r[i] && !found) begin
        found = 1'b1;
        if (e) g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  // Reference index: position of the highest request when enabled, else 0.
  function automatic int refIdx(input logic [7:0] r, input logic e, input int w);
    int idx;
    logic found;
    idx = 0;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (r[i] && !found) begin
        found = 1'b1;
        if (e) idx = i;
      end
    end
    return idx;
  endfunction

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare all combinational outputs of both instances against the model.
  task automatic checkComb(input string tag);
    logic [7:0] g4;
    logic [7:0] g8;
    g4 = refGnt({4'b0, req4}, en4, 4);
    g8 = refGnt(req8, en8, 8);
    checkOutput({tag, " gnt4"}, gnt4, g4[3:0]);
    checkOutput({tag, " gntAny4"}, gntAny4, |g4);
    checkOutput({tag, " reqAny4"}, reqAny4, |req4);
    checkOutput({tag, " idx4"}, idx4, refIdx({4'b0, req4}, en4, 4));
    checkOutput({tag, " onehot4"}, ($countones(gnt4) <= 1), 1);
    checkOutput({tag, " gnt8"}, gnt8, g8);
    checkOutput({tag, " gntAny8"}, gntAny8, |g8);
    checkOutput({tag, " reqAny8"}, reqAny8, |req8);
    checkOutput({tag, " idx8"}, idx8, refIdx(req8, en8, 8));
    checkOutput({tag, " onehot8"}, ($countones(gnt8) <= 1), 1);
  endtask

  // Compare registered outputs against the grant captured at the last edge.
  task automatic checkRegs(input string tag);
    checkOutput({tag, " gntQ4"}, gntQ4, expQ4[3:0]);
    checkOutput({tag, " gntAnyQ4"}, gntAnyQ4, |expQ4);
    checkOutput({tag, " gntQ8"}, gntQ8, expQ8);
    checkOutput({tag, " gntAnyQ8"}, gntAnyQ8, |expQ8);
  endtask

  // One step: at the falling edge, check what the last rising edge captured,
  // then drive new inputs and check that the combinational outputs follow
  // while the registered outputs hold their value.
  task automatic applyStimulus(input string tag, input logic [3:0] r4, input logic e4,
                               input logic [7:0] r8, input logic e8);
    @(negedge clock);
    if (reset) begin
      expQ4 = '0;
      expQ8 = '0;
    end else begin
      expQ4 = refGnt({4'b0, req4}, en4, 4);
      expQ8 = refGnt(req8, en8, 8);
    end
    checkRegs({tag, " pre"});
    req4 = r4;
    en4  = e4;
    req8 = r8;
    en8  = e8;
    #1;
    checkComb(tag);
    checkRegs({tag, " hold"});
  endtask

  logic [3:0] dirReq [13] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001,
                              4'b0101, 4'b0110, 4'b1110, 4'b1111,
                              4'b1111, 4'b0110, 4'b0000, 4'b0000};
  logic       dirEn  [13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    req4 = '0;
    en4 = 1'b0;
    req8 = '0;
    en8 = 1'b0;
    expQ4 = '0;
    expQ8 = '0;

    // Registered outputs must be clear under reset before any clock edge.
    #2;
    checkRegs("reset");
    checkComb("reset");

    // Combinational outputs keep working while reset is held.
    req4 = 4'b0110;
    en4 = 1'b1;
    req8 = 8'b0010_0100;
    en8 = 1'b1;
    #1;
    checkComb("combInReset");
    @(negedge clock);
    checkRegs("heldReset");
    req4 = '0;
    en4 = 1'b0;
    req8 = '0;
    en8 = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Directed sweep from the test plan, with the 8-bit instance mirroring it.
    for (int k = 0; k < 13; k++) begin
      applyStimulus($sformatf("dir%0d", k), dirReq[k], dirEn[k],
                    {dirReq[k], dirReq[k]}, dirEn[k]);
    end

    // Registered path: a grant shows up on gnt_q exactly one edge later.
    applyStimulus("regIdle", 4'b0000, 1'b0, 8'h00, 1'b0);
    applyStimulus("regApply", 4'b0010, 1'b1, 8'h02, 1'b1);
    applyStimulus("regHold", 4'b0010, 1'b1, 8'h02, 1'b1);

    // Asynchronous reset between edges clears gnt_q at once; gnt keeps tracking.
    applyStimulus("top1", 4'b1000, 1'b1, 8'h80, 1'b1);
    applyStimulus("top2", 4'b1000, 1'b1, 8'h80, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("asyncRst gntQ4", gntQ4, 4'b0000);
    checkOutput("asyncRst gntAnyQ4", gntAnyQ4, 1'b0);
    checkOutput("asyncRst gntQ8", gntQ8, 8'h00);
    checkOutput("asyncRst gntAnyQ8", gntAnyQ8, 1'b0);
    checkOutput("asyncRst gnt4", gnt4, 4'b1000);
    checkComb("asyncRst");
    reset = 1'b0;
    applyStimulus("afterRst", 4'b0001, 1'b1, 8'h01, 1'b1);

    // Exhaustive: every 8-bit request with both enable values; the 4-bit
    // instance gets a folded copy, so it also sees every value.
    for (int k = 0; k < 512; k++) begin
      applyStimulus("exh", 4'(k) ^ 4'(k >> 4), k[8], 8'(k), k[8]);
    end

    // Random patterns with independent enables.
    for (int k = 0; k < 200; k++) begin
      applyStimulus("rnd", 4'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end

    @(negedge clock);
    expQ4 = refGnt({4'b0, req4}, en4, 4);
    expQ8 = refGnt(req8, en8, 8);
    checkRegs("final");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
